// File: rtl/aes_pkg.sv
// Shared constants and types for the AES stream sequencer.
// Holds the command/mode codes, the sequencer state encoding and the
// block/word widths used by the controller and its word packer.
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;

  localparam logic [1:0] AES_ENCRYPT    = 2'b00;
  localparam logic [1:0] AES_DECRYPT    = 2'b01;
  localparam logic [1:0] AES_EXPAND_KEY = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } aes_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// 4-word packer: serial-in/parallel-out while loading, parallel-in/serial-out while draining.
// Ports: clr/ld/wr/sh select the operation (priority in that order), word is the serial
// input, block the parallel input, q the assembled block, head the word at [127:96], cnt the word index.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  ld,
  input  logic                  wr,
  input  logic                  sh,
  input  logic [AES_WORD_W-1:0] word,
  input  logic [AES_BLK_W-1:0]  block,
  output logic [AES_BLK_W-1:0]  q,
  output logic [AES_WORD_W-1:0] head,
  output logic [1:0]            cnt
);

  assign head = q[AES_BLK_W-1 -: AES_WORD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= 2'd0;
    end else if (clr) begin
      q   <= '0;
      cnt <= 2'd0;
    end else if (ld) begin
      q   <= block;
      cnt <= 2'd0;
    end else if (wr) begin
      // Words are placed by index into a cleared register, so a short
      // packet leaves the unwritten low words at zero.
      case (cnt)
        2'd0:    q[127:96] <= word;
        2'd1:    q[95:64]  <= word;
        2'd2:    q[63:32]  <= word;
        default: q[31:0]   <= word;
      endcase
      cnt <= cnt + 2'd1;
    end else if (sh) begin
      // Zeros shifted in leave the register clean for the next block.
      q   <= {q[AES_BLK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Sequencer between the command register, 32-bit AXI-Stream ports and the 128-bit AES core.
// Ports: cmd/cmd_valid/cmd_ready command, s_axis_* input words, m_axis_* output words,
// core_* core handshake, aes_done/busy/key_valid/err/blk_count status (busy=status_0, err=status_1).
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [1:0]            cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  err_clear,
  input  logic [AES_WORD_W-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [AES_WORD_W-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  core_start,
  output logic [1:0]            core_mode,
  output logic [AES_BLK_W-1:0]  core_din,
  input  logic                  core_done,
  input  logic [AES_BLK_W-1:0]  core_dout,
  output logic                  aes_done,
  output logic                  busy,
  output logic                  key_valid,
  output logic                  err,
  output logic [CNT_W-1:0]      blk_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  aes_state_t            state;
  logic [1:0]            mode;
  logic                  last_blk;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [AES_BLK_W-1:0]  blk;
  logic [AES_WORD_W-1:0] head;
  logic [1:0]            cnt;

  logic enc_dec, accept, s_hs, m_hs, short_last, tmo_hit, drain_end, err_set;

  assign enc_dec    = (cmd == AES_ENCRYPT) || (cmd == AES_DECRYPT);
  assign accept     = (state == ST_IDLE) && cmd_valid &&
                      ((cmd == AES_EXPAND_KEY) || (enc_dec && key_valid));
  assign s_hs       = (state == ST_LOAD) && s_axis_tvalid;
  assign m_hs       = (state == ST_DRAIN) && m_axis_tready;
  assign short_last = s_hs && s_axis_tlast && (mode != AES_EXPAND_KEY) && (cnt != 2'd3);
  assign tmo_hit    = (state == ST_WAIT) && !core_done && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign drain_end  = m_hs && (cnt == 2'd3);
  assign err_set    = ((state == ST_IDLE) && cmd_valid &&
                       ((enc_dec && !key_valid) || (cmd == 2'b11))) ||
                      short_last || tmo_hit;

  aes_word_packer u_packer (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .clr   (accept || (drain_end && !last_blk)),
    .ld    ((state == ST_WAIT) && core_done),
    .wr    (s_hs),
    .sh    (m_hs),
    .word  (s_axis_tdata),
    .block (core_dout),
    .q     (blk),
    .head  (head),
    .cnt   (cnt)
  );

  // Stream and core strobes decode straight from the state register; START
  // and each pulse state last exactly one cycle.
  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign s_axis_tready = (state == ST_LOAD);
  assign m_axis_tvalid = (state == ST_DRAIN);
  assign m_axis_tdata  = head;
  assign m_axis_tlast  = (state == ST_DRAIN) && last_blk && (cnt == 2'd3);
  assign core_start    = (state == ST_START);
  assign core_mode     = mode;
  assign core_din      = blk;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= ST_IDLE;
      mode      <= AES_ENCRYPT;
      last_blk  <= 1'b0;
      tmo_cnt   <= '0;
      aes_done  <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      blk_count <= '0;
    end else begin
      aes_done <= 1'b0;
      // A new error in the same cycle as err_clear wins.
      err      <= err_set || (err && !err_clear);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode      <= cmd;
            blk_count <= '0;
            last_blk  <= 1'b0;
            state     <= ST_LOAD;
          end else if (cmd_valid && enc_dec) begin
            aes_done <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (s_hs) begin
            if (s_axis_tlast && (mode != AES_EXPAND_KEY)) begin
              last_blk <= 1'b1;
              state    <= ST_START;
            end else if (cnt == 2'd3) begin
              state <= ST_START;
            end
          end
        end
        ST_START: begin
          if (mode == AES_EXPAND_KEY) key_valid <= 1'b0;
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            if (blk_count != {CNT_W{1'b1}}) blk_count <= blk_count + 1'b1;
            if (mode == AES_EXPAND_KEY) begin
              key_valid <= 1'b1;
              aes_done  <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (tmo_hit) begin
            // Leaving WAIT means any later core_done is simply not looked at.
            key_valid <= 1'b0;
            aes_done  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            if (last_blk) begin
              aes_done <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a stub AES core.
// Inputs change #1 after posedge; outputs are sampled on negedge.
// The stub answers the FIPS-197 ENCRYPT vector and returns ~din for any other block.
module tb_aes_stream_ctrl;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [1:0]   cmd = 2'b00;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         err_clear = 1'b0;
  logic [31:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic         core_start;
  logic [1:0]   core_mode;
  logic [127:0] core_din;
  logic         core_done = 1'b0;
  logic [127:0] core_dout = '0;
  logic         aes_done;
  logic         busy;
  logic         key_valid;
  logic         err;
  logic [15:0]  blk_count;

  aes_stream_ctrl #(.TIMEOUT_CYCLES(1024), .CNT_W(16)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .err_clear(err_clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .core_start(core_start), .core_mode(core_mode), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout),
    .aes_done(aes_done), .busy(busy), .key_valid(key_valid), .err(err),
    .blk_count(blk_count)
  );

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_chk  = 0;
  int n_pass = 0;

  logic         stub_en    = 1'b1;
  logic         rdy_toggle = 1'b0;
  logic [31:0]  out_dat[$];
  logic         out_last[$];
  logic [127:0] start_din[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stub core: answers 3 cycles after the start strobe unless disabled.
  initial begin
    logic [127:0] din;
    logic [1:0]   md;
    forever begin
      @(negedge clk);
      if (core_start && stub_en) begin
        din = core_din;
        md  = core_mode;
        repeat (3) @(posedge clk);
        #1;
        core_done = 1'b1;
        core_dout = (md == 2'b00 && din == PT) ? CT : ~din;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_toggle) m_axis_tready = ~m_axis_tready;
  end

  // Output monitor: records handshakes and start strobes, checks hold-while-stalled
  // and single-cycle pulses.
  initial begin
    logic        prev_hold = 1'b0;
    logic [31:0] prev_dat  = '0;
    logic        prev_start = 1'b0;
    logic        prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_hold && m_axis_tvalid) check("m_hold", 128'(m_axis_tdata), 128'(prev_dat));
      if (prev_start) check("start_pulse", 128'(core_start), 128'(0));
      if (prev_done)  check("done_pulse", 128'(aes_done), 128'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        out_dat.push_back(m_axis_tdata);
        out_last.push_back(m_axis_tlast);
      end
      if (core_start) start_din.push_back(core_din);
      prev_hold  = m_axis_tvalid && !m_axis_tready;
      prev_dat   = m_axis_tdata;
      prev_start = core_start;
      prev_done  = aes_done;
    end
  end

  task automatic cmd_pulse(input logic [1:0] c);
    @(posedge clk); #1;
    cmd = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin ok = 1'b1; break; end
    end
    if (!ok) check("s_ready_timeout", 128'(0), 128'(1));
    else @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (aes_done) begin seen = 1'b1; break; end
    end
    if (!seen) check("aes_done_timeout", 128'(0), 128'(1));
  endtask

  task automatic clear_mon();
    out_dat.delete(); out_last.delete(); start_din.delete();
  endtask

  initial begin
    int cyc;
    logic [31:0] w;

    // Reset values
    #12;
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_key_valid", 128'(key_valid), 128'(0));
    check("rst_blk_count", 128'(blk_count), 128'(0));
    check("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_s_tready", 128'(s_axis_tready), 128'(0));
    check("rst_core_start", 128'(core_start), 128'(0));
    @(posedge clk); #1; aresetn = 1'b1;

    // ENCRYPT with no key
    cmd_pulse(2'b00);
    check("nokey_err", 128'(err), 128'(1));
    check("nokey_done", 128'(aes_done), 128'(1));
    check("nokey_idle", 128'(busy), 128'(0));
    check("nokey_s_tready", 128'(s_axis_tready), 128'(0));
    @(posedge clk); #1;
    check("nokey_done_drop", 128'(aes_done), 128'(0));
    clear_err();
    check("err_clear", 128'(err), 128'(0));
    cmd_pulse(2'b11);
    check("bad_cmd_err", 128'(err), 128'(1));
    check("bad_cmd_idle", 128'(busy), 128'(0));
    clear_err();

    // EXPAND_KEY, tlast on word 2 is ignored, command mid-load ignored
    clear_mon();
    cmd_pulse(2'b10);
    check("ek_busy", 128'(busy), 128'(1));
    push(32'h00010203, 1'b0);
    cmd_pulse(2'b11);
    check("ek_cmd_ignored_err", 128'(err), 128'(0));
    check("ek_cmd_ignored_ready", 128'(cmd_ready), 128'(0));
    push(32'h04050607, 1'b1);
    push(32'h08090a0b, 1'b0);
    push(32'h0c0d0e0f, 1'b0);
    wait_done(100, cyc);
    check("ek_starts", 128'(start_din.size()), 128'(1));
    if (start_din.size() > 0) check("ek_din", start_din[0], KEY);
    check("ek_key_valid", 128'(key_valid), 128'(1));
    check("ek_no_out", 128'(out_dat.size()), 128'(0));
    check("ek_err", 128'(err), 128'(0));

    // FIPS-197 single block
    clear_mon();
    cmd_pulse(2'b00);
    push(32'h00112233, 1'b0);
    push(32'h44556677, 1'b0);
    push(32'h8899aabb, 1'b0);
    push(32'hccddeeff, 1'b1);
    check("enc_start_latency", 128'(core_start), 128'(1));
    wait_done(100, cyc);
    check("enc_n_out", 128'(out_dat.size()), 128'(4));
    if (out_dat.size() == 4) begin
      check("enc_w0", 128'(out_dat[0]), 128'(32'h69c4e0d8));
      check("enc_w1", 128'(out_dat[1]), 128'(32'h6a7b0430));
      check("enc_w2", 128'(out_dat[2]), 128'(32'hd8cdb780));
      check("enc_w3", 128'(out_dat[3]), 128'(32'h70b4c55a));
      check("enc_last", 128'({out_last[0], out_last[1], out_last[2], out_last[3]}), 128'(4'b0001));
    end
    check("enc_blk_count", 128'(blk_count), 128'(1));
    check("enc_err", 128'(err), 128'(0));

    // Three blocks with toggling tready
    clear_mon();
    rdy_toggle = 1'b1;
    cmd_pulse(2'b00);
    for (int i = 0; i < 12; i++) push(32'h10000000 + 32'(i) * 32'h0101, i == 11);
    wait_done(400, cyc);
    rdy_toggle = 1'b0;
    @(posedge clk); #1; m_axis_tready = 1'b1;
    check("blk3_n_out", 128'(out_dat.size()), 128'(12));
    check("blk3_starts", 128'(start_din.size()), 128'(3));
    if (out_dat.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        w = ~(32'h10000000 + 32'(i) * 32'h0101);
        check($sformatf("blk3_w%0d", i), 128'(out_dat[i]), 128'(w));
        check($sformatf("blk3_last%0d", i), 128'(out_last[i]), 128'(i == 11));
      end
    end
    check("blk3_blk_count", 128'(blk_count), 128'(3));

    // Short packet: tlast on word 2
    clear_mon();
    cmd_pulse(2'b00);
    push(32'hdeadbeef, 1'b0);
    push(32'h01234567, 1'b1);
    wait_done(100, cyc);
    if (start_din.size() > 0) begin
      check("short_din", start_din[0], 128'hdeadbeef_01234567_00000000_00000000);
    end else check("short_started", 128'(0), 128'(1));
    check("short_err", 128'(err), 128'(1));
    check("short_n_out", 128'(out_dat.size()), 128'(4));
    if (out_dat.size() == 4) begin
      check("short_w0", 128'(out_dat[0]), 128'(32'h21524110));
      check("short_w1", 128'(out_dat[1]), 128'(32'hfedcba98));
      check("short_w3", 128'(out_dat[3]), 128'(32'hffffffff));
      check("short_last", 128'({out_last[0], out_last[1], out_last[2], out_last[3]}), 128'(4'b0001));
    end
    clear_err();

    // Core never answers: timeout
    stub_en = 1'b0;
    cmd_pulse(2'b00);
    for (int i = 0; i < 4; i++) push(32'hcafe0000 + 32'(i), i == 3);
    wait_done(1200, cyc);
    check("tmo_min", 128'(cyc >= 1024), 128'(1));
    check("tmo_max", 128'(cyc <= 1040), 128'(1));
    check("tmo_err", 128'(err), 128'(1));
    check("tmo_key_valid", 128'(key_valid), 128'(0));
    @(posedge clk); #1;
    check("tmo_busy", 128'(busy), 128'(0));
    stub_en = 1'b1;

    // Reset while draining
    cmd_pulse(2'b10);
    for (int i = 0; i < 4; i++) push(32'(i), 1'b0);
    wait_done(100, cyc);
    m_axis_tready = 1'b0;
    cmd_pulse(2'b00);
    for (int i = 0; i < 4; i++) push(32'h55000000 + 32'(i), i == 3);
    cyc = 0;
    while (!m_axis_tvalid && cyc < 50) begin @(negedge clk); cyc++; end
    check("drain_tvalid", 128'(m_axis_tvalid), 128'(1));
    check("drain_key_valid", 128'(key_valid), 128'(1));
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("mid_rst_tdata", 128'(m_axis_tdata), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("mid_rst_key_valid", 128'(key_valid), 128'(0));
    check("mid_rst_blk_count", 128'(blk_count), 128'(0));
    check("mid_rst_err", 128'(err), 128'(0));
    @(posedge clk); #1;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Sequencer between the AXI-Lite command register, the 32-bit AXI-Stream ports and the 128-bit AES round core.
- Accepts one command: ENCRYPT=2'b00, DECRYPT=2'b01 or EXPAND_KEY=2'b10.
- Gathers four stream words into a 128-bit block and starts the core, then waits for core completion.
- For ENCRYPT/DECRYPT it serialises the result back out as four words, one block after another, until the input packet ends.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for core_done before aborting; width is clog2(TIMEOUT_CYCLES+1).
- CNT_W, 16: width of blk_count.

Ports:
- s00_axi_aclk  in  1  single clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- cmd  in  2  command code
- cmd_valid  in  1  command strobe from the register file
- cmd_ready  out  1  high only in IDLE
- err_clear  in  1  clears the err sticky flag
- s_axis_tdata  in  32  input word
- s_axis_tvalid  in  1
- s_axis_tlast  in  1
- s_axis_tready  out  1
- m_axis_tdata  out  32  output word
- m_axis_tvalid  out  1
- m_axis_tlast  out  1
- m_axis_tready  in  1
- core_start  out  1  one-cycle start pulse to the core
- core_mode  out  2  held stable from START until done
- core_din  out  128  key or block presented to the core
- core_done  in  1  one-cycle completion pulse
- core_dout  in  128  core result, valid when core_done=1
- aes_done  out  1  one-cycle pulse when a command completes
- busy  out  1  high whenever state is not IDLE
- key_valid  out  1  an expanded key is held in the core
- err  out  1  sticky error flag
- blk_count  out  CNT_W  number of blocks completed by the current or last command

Behaviour:
- Reset values (asynchronous on s00_axi_aresetn low): state=IDLE, all outputs 0 except cmd_ready=1, key_valid=0, blk_count=0.
- States: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE:
  - cmd_valid with cmd=EXPAND_KEY, or ENCRYPT/DECRYPT with key_valid=1: latch the mode, clear blk_count, go to LOAD.
  - ENCRYPT/DECRYPT with key_valid=0: set err, pulse aes_done, stay in IDLE.
  - cmd=2'b11: set err, stay in IDLE.
- LOAD:
  - s_axis_tready=1. Each handshake shifts the word in; the first word lands in bits [127:96] (big-endian word order).
  - After the 4th word, go to START.
  - tlast on word k<4: zero-fill the remaining words, set err, go to START. This block is the last one.
  - EXPAND_KEY ignores tlast; it always takes exactly 4 words.
- START:
  - core_start=1 for one cycle; core_din=assembled block.
  - If mode=EXPAND_KEY, clear key_valid here.
  - Go to WAIT.
- WAIT:
  - On core_done, capture core_dout and increment blk_count (saturating at all ones).
  - EXPAND_KEY: set key_valid, pulse aes_done, go to IDLE.
  - ENCRYPT/DECRYPT: go to DRAIN.
  - Timeout counter reaching TIMEOUT_CYCLES: set err, key_valid=0, pulse aes_done, go to IDLE. A late core_done after this is ignored.
- DRAIN:
  - m_axis_tvalid=1 with word [127:96] first. tdata/tvalid must stay stable until the tready handshake.
  - After the 4th handshake:
    - if the input block ended with tlast (or a short tlast), assert m_axis_tlast on that 4th word, pulse aes_done and go to IDLE;
    - otherwise go to LOAD.
- Latency: from the 4th input handshake, core_start occurs 1 cycle later. From core_done, the first output word is valid 1 cycle later.
- s_axis_tready=0 outside LOAD, so there is no overlap between loading and draining.
- cmd_valid outside IDLE is ignored and never latched.
- err_clear: clears err unless a new error is set in the same cycle; set wins.
- aes_done and core_start are never high for more than 1 cycle.
- status mapping for top-level status_0/status_1: status_0=busy, status_1=err.

Decomposition:
- Shared package aes_pkg holds:
  - mode constants AES_ENCRYPT=2'b00, AES_DECRYPT=2'b01, AES_EXPAND_KEY=2'b10;
  - the state enumeration;
  - the AES_BLK_W=128 and AES_WORD_W=32 constants.
- One natural sub-module: aes_word_packer, a 4-word shift register with word counter.
  - Serial-in-parallel-out for LOAD and parallel-in-serial-out for DRAIN.
  - Reused in both directions via a load/shift select.

Test Plan:
- EXPAND_KEY, then stream key 00010203,04050607,08090a0b,0c0d0e0f → one core_start with core_din=000102030405060708090a0b0c0d0e0f; after core_done: key_valid=1, aes_done pulse, no m_axis traffic.
- Then ENCRYPT with 00112233,44556677,8899aabb,ccddeeff (tlast on word 4), using the team AES core → output 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, tlast on word 4, blk_count=1.
- ENCRYPT of 3 blocks (12 words, tlast on word 12), with m_axis_tready toggling 1/0 each cycle → 12 output words in order, data held stable while tready=0, tlast only on word 12, blk_count=3.
- ENCRYPT immediately after reset (key_valid=0) → err=1, aes_done pulse, state stays IDLE, s_axis_tready=0. err_clear → err=0.
- Short packet: tlast on word 2 → core_din low 64 bits are zero, err=1, 4 words output with tlast on word 4.
- Core stub never returns core_done → after 1024 cycles in WAIT: err=1, key_valid=0, busy=0. Also assert reset mid-DRAIN → all outputs at reset values immediately.
